uart_flit_tx: RTL and testbench



---
 rtl/types.sv | 22 ++
 rtl/uart_byte_tx.sv | 85 ++++++++
 rtl/uart_flit_tx.sv | 79 +++++++
 tb/tb_uart_flit_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/types.sv
// Types and constants shared by the UART flit transmitter and its receiver.
package types;
  localparam int FLIT_WIDTH = 128;
  typedef logic [FLIT_WIDTH-1:0] flit_t;

  localparam int FLIT_BYTES       = 16;
  localparam int UART_FRAME_BYTES = FLIT_BYTES + 1;

  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_START,
    BS_DATA,
    BS_STOP
  } byte_state_e;

  typedef enum logic {
    FS_IDLE,
    FS_SEND
  } flit_state_e;
endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
// byte_ready_o also rises on the last stop cycle so consecutive bytes chain with no idle gap.
module uart_byte_tx
  import types::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       tx_o
);
  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  byte_state_e      state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             cell_end;

  assign cell_end     = (baud_q == CNT_LAST);
  assign byte_ready_o = (state_q == BS_IDLE) || ((state_q == BS_STOP) && cell_end);
  assign tx_o         = tx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BS_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        BS_IDLE: begin
          baud_q <= '0;
          if (byte_valid_i) begin
            shift_q <= byte_i;
            tx_q    <= 1'b0;
            state_q <= BS_START;
          end
        end
        BS_START: begin
          baud_q <= cell_end ? '0 : baud_q + 1'b1;
          if (cell_end) begin
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= BS_DATA;
          end
        end
        BS_DATA: begin
          baud_q <= cell_end ? '0 : baud_q + 1'b1;
          if (cell_end) begin
            // Shift right so the next bit to send is always shift_q[0].
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= BS_STOP;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        BS_STOP: begin
          baud_q <= cell_end ? '0 : baud_q + 1'b1;
          if (cell_end) begin
            if (byte_valid_i) begin
              shift_q <= byte_i;
              tx_q    <= 1'b0;
              state_q <= BS_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= BS_IDLE;
            end
          end
        end
        default: state_q <= BS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_flit_tx.sv
// Serializes one 128-bit flit per handshake as a 17-byte UART frame: sync byte, then
// flit bytes [7:0] upward. The flit is latched on accept so later input changes are ignored.
module uart_flit_tx
  import types::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = UART_SYNC_BYTE
) (
  input  logic  cpuclk,
  input  logic  rst_n,
  input  flit_t flit_in,
  input  logic  flit_in_valid,
  output logic  flit_in_ready,
  output logic  uart_tx,
  output logic  tx_busy
);
  flit_state_e state_q;
  flit_t       hold_q;
  logic [4:0]  byte_idx_q;
  logic [7:0]  byte_d;
  logic        byte_valid_d;
  logic        byte_ready;
  logic        accept;

  assign flit_in_ready = (state_q == FS_IDLE) && rst_n;
  assign tx_busy       = (state_q != FS_IDLE);
  assign accept        = flit_in_valid && flit_in_ready;

  // The sync byte goes straight from the accept; flit bytes come from the holding register.
  always_comb begin
    byte_valid_d = 1'b0;
    byte_d       = SYNC_BYTE;
    if (state_q == FS_IDLE) begin
      byte_valid_d = accept;
    end else if (byte_idx_q != 5'(FLIT_BYTES)) begin
      byte_valid_d = 1'b1;
      byte_d       = hold_q[{byte_idx_q[3:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge cpuclk) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      hold_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      unique case (state_q)
        FS_IDLE: begin
          if (accept) begin
            hold_q     <= flit_in;
            byte_idx_q <= '0;
            state_q    <= FS_SEND;
          end
        end
        FS_SEND: begin
          if (byte_ready) begin
            if (byte_idx_q == 5'(FLIT_BYTES)) begin
              state_q <= FS_IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk         (cpuclk),
    .rst_n       (rst_n),
    .byte_i      (byte_d),
    .byte_valid_i(byte_valid_d),
    .byte_ready_o(byte_ready),
    .tx_o        (uart_tx)
  );
endmodule

// File: tb/tb_uart_flit_tx.sv
// Bench for uart_flit_tx: two instances (4 and 2 clocks per bit) checked every cycle
// against a frame-level line model, plus a line decoder and literal expectations.
module tb_uart_flit_tx;
  import types::*;

  localparam int NI = 2;

  logic  cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  logic  rst_n;
  flit_t flit_in [NI];
  logic  valid   [NI];
  logic  ready   [NI];
  logic  tx      [NI];
  logic  busy    [NI];

  int checks   = 0;
  int failures = 0;

  int         acc_cnt [NI];
  logic [7:0] rxbuf   [NI][256];
  int         rxn     [NI];

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  function automatic flit_t rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int CPB = (g == 0) ? 4 : 2;

    uart_flit_tx #(.CLKS_PER_BIT(CPB)) dut (
      .cpuclk       (cpuclk),
      .rst_n        (rst_n),
      .flit_in      (flit_in[g]),
      .flit_in_valid(valid[g]),
      .flit_in_ready(ready[g]),
      .uart_tx      (tx[g]),
      .tx_busy      (busy[g])
    );

    // Model: the expected line level for every remaining cycle of the current frame.
    bit         expq[$];
    bit         model_on = 1'b0;
    bit         was_idle;
    bit         lv;
    logic [7:0] by;

    always @(posedge cpuclk) begin
      was_idle = (expq.size() == 0);
      if (!rst_n) begin
        expq.delete();
        model_on = 1'b1;
      end else if (model_on) begin
        if (!was_idle) void'(expq.pop_front());
        if (was_idle && valid[g]) begin
          acc_cnt[g]++;
          for (int b = 0; b < 17; b++) begin
            if (b == 0) by = 8'hA5;
            else        by = flit_in[g][8*(b-1) +: 8];
            for (int k = 0; k < 10; k++) begin
              if (k == 0)      lv = 1'b0;
              else if (k == 9) lv = 1'b1;
              else             lv = by[k-1];
              repeat (CPB) expq.push_back(lv);
            end
          end
        end
      end
    end

    always @(negedge cpuclk) begin
      if (model_on) begin
        chk("tx", g, 128'(tx[g]), (expq.size() != 0) ? 128'(expq[0]) : 128'd1);
        chk("busy", g, 128'(busy[g]), 128'(expq.size() != 0));
        chk("ready", g, 128'(ready[g]), 128'((expq.size() == 0) && rst_n));
      end
    end

    // Line decoder: samples mid-cell from the falling edge of each start bit.
    int         dcnt = -1;
    int         kb;
    logic [7:0] dsh;

    always @(negedge cpuclk) begin
      if (!rst_n) begin
        dcnt = -1;
      end else if (dcnt < 0) begin
        if (tx[g] === 1'b0) dcnt = 0;
      end else begin
        dcnt++;
        if ((dcnt % CPB) == (CPB / 2)) begin
          kb = dcnt / CPB;
          if (kb >= 1 && kb <= 8) begin
            dsh[kb-1] = tx[g];
          end else if (kb == 9) begin
            chk("stop_bit", g, 128'(tx[g]), 128'd1);
            if (rxn[g] < 256) begin
              rxbuf[g][rxn[g]] = dsh;
              rxn[g]++;
            end
            dcnt = -1;
          end
        end
      end
    end
  end

  task automatic send(input int g, input flit_t f, input bit jitter);
    int n = 0;
    flit_in[g] = f;
    valid[g]   = 1'b1;
    while (!ready[g] && n < 5000) begin
      @(posedge cpuclk); #1;
      n++;
      if (jitter && !ready[g] && $urandom_range(0, 7) == 0) flit_in[g] = rnd_flit();
    end
    if (!ready[g]) chk("ready_timeout", g, 128'd0, 128'd1);
    @(posedge cpuclk); #1;
    valid[g] = 1'b0;
  endtask

  task automatic count_busy(input int g, output int n);
    n = 0;
    while (busy[g] && n < 5000) begin
      n++;
      @(posedge cpuclk); #1;
    end
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] && n < 5000) begin
      @(posedge cpuclk); #1;
      n++;
    end
    if (busy[g]) chk("idle_timeout", g, 128'd1, 128'd0);
  endtask

  initial begin
    int    base, bc, acc0, edges;
    logic  prev;
    flit_t r;

    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      valid[g]   = 1'b0;
      flit_in[g] = '0;
    end

    // Reset state
    repeat (3) @(posedge cpuclk);
    #1;
    chk("rst_ready", 0, 128'(ready[0]), 128'd0);
    chk("rst_tx", 0, 128'(tx[0]), 128'd1);
    chk("rst_busy", 0, 128'(busy[0]), 128'd0);
    rst_n = 1'b1;
    @(posedge cpuclk); #1;
    chk("post_rst_ready", 0, 128'(ready[0]), 128'd1);

    // Single known flit
    base = rxn[0];
    send(0, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
    chk("start_next_cycle", 0, 128'(tx[0]), 128'd0);
    count_busy(0, bc);
    chk("busy_cycles", 0, 128'(bc), 128'd680);
    chk("ready_after", 0, 128'(ready[0]), 128'd1);
    chk("byte_count", 0, 128'(rxn[0] - base), 128'd17);
    chk("sync_byte", 0, 128'(rxbuf[0][base]), 128'hA5);
    for (int i = 0; i < 16; i++) chk("flit_byte", i, 128'(rxbuf[0][base+1+i]), 128'(i));

    // Back-to-back: all-ones then all-zeros with valid held
    base = rxn[0];
    acc0 = acc_cnt[0];
    send(0, '1, 1'b0);
    valid[0]   = 1'b1;
    flit_in[0] = '0;
    wait_idle(0);
    chk("gap_idle_tx", 0, 128'(tx[0]), 128'd1);
    chk("gap_ready", 0, 128'(ready[0]), 128'd1);
    @(posedge cpuclk); #1;
    valid[0] = 1'b0;
    chk("second_start", 0, 128'(tx[0]), 128'd0);
    chk("second_busy", 0, 128'(busy[0]), 128'd1);
    wait_idle(0);
    chk("b2b_accepts", 0, 128'(acc_cnt[0] - acc0), 128'd2);
    chk("b2b_bytes", 0, 128'(rxn[0] - base), 128'd34);
    chk("b2b_ones", 0, 128'(rxbuf[0][base+5]), 128'hFF);
    chk("b2b_sync2", 0, 128'(rxbuf[0][base+17]), 128'hA5);
    chk("b2b_zeros", 0, 128'(rxbuf[0][base+30]), 128'h00);

    // Input changed mid-frame with valid still high
    base = rxn[0];
    acc0 = acc_cnt[0];
    r    = rnd_flit();
    send(0, r, 1'b0);
    valid[0]   = 1'b1;
    flit_in[0] = '0;
    repeat (300) begin @(posedge cpuclk); #1; end
    valid[0] = 1'b0;
    wait_idle(0);
    chk("mid_accepts", 0, 128'(acc_cnt[0] - acc0), 128'd1);
    for (int i = 0; i < 16; i++) chk("mid_byte", i, 128'(rxbuf[0][base+1+i]), 128'(r[8*i +: 8]));

    // Reset pulse during data bits of frame byte 5
    acc0 = acc_cnt[0];
    send(0, rnd_flit(), 1'b0);
    repeat (210) begin @(posedge cpuclk); #1; end
    rst_n = 1'b0;
    @(posedge cpuclk); #1;
    chk("abort_tx", 0, 128'(tx[0]), 128'd1);
    chk("abort_busy", 0, 128'(busy[0]), 128'd0);
    chk("abort_ready", 0, 128'(ready[0]), 128'd0);
    rst_n = 1'b1;
    edges = 0;
    prev  = tx[0];
    repeat (150) begin
      @(posedge cpuclk); #1;
      if (tx[0] !== prev) edges++;
      prev = tx[0];
    end
    chk("abort_edges", 0, 128'(edges), 128'd0);
    chk("abort_accepts", 0, 128'(acc_cnt[0] - acc0), 128'd1);

    // Two clocks per bit, alternating pattern
    base = rxn[1];
    send(1, {16{8'hAA}}, 1'b0);
    chk("cpb2_start", 1, 128'(tx[1]), 128'd0);
    count_busy(1, bc);
    chk("cpb2_frame", 1, 128'(bc), 128'd340);
    chk("cpb2_bytes", 1, 128'(rxn[1] - base), 128'd17);
    chk("cpb2_sync", 1, 128'(rxbuf[1][base]), 128'hA5);
    chk("cpb2_last", 1, 128'(rxbuf[1][base+16]), 128'hAA);

    // Randomized traffic on both instances
    for (int n = 0; n < 5; n++) begin
      send(1, rnd_flit(), 1'b1);
      repeat ($urandom_range(0, 3)) begin @(posedge cpuclk); #1; end
    end
    for (int n = 0; n < 2; n++) begin
      send(0, rnd_flit(), 1'b1);
      repeat ($urandom_range(0, 3)) begin @(posedge cpuclk); #1; end
    end
    wait_idle(0);
    wait_idle(1);
    repeat (4) begin @(posedge cpuclk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
